// File: rtl/spi_sample_sequencer.sv
// spi_sample_sequencer: periodically arms spi_master_ss with a fixed command
// word, captures each from_slave result and queues it in a FWFT FIFO.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   enable            run the sampling loop
//   cmd               word sent to the slave on each transfer (latched at arm)
//   period            minimum cycles between consecutive arm rises
//   spi_ready_to_arm  handshake from spi_master_ss
//   spi_finished      handshake from spi_master_ss
//   spi_from_slave    received word from spi_master_ss
//   spi_arm           arm request to spi_master_ss
//   spi_to_slave      command word to spi_master_ss
//   rd_en             pop FIFO head
//   rd_data           FIFO head, valid when rd_valid
//   rd_valid          FIFO not empty
//   fifo_level        entries stored, 0..2**FIFO_AW
//   overflow          sticky: a sample was dropped on a full FIFO
//   clr_overflow      clear overflow (a same-cycle drop wins)
//   busy              sequencer not idle
module spi_sample_sequencer #(
    parameter int WID        = 24,
    parameter int PERIOD_WID = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [WID-1:0]        cmd,
    input  logic [PERIOD_WID-1:0] period,
    input  logic                  spi_ready_to_arm,
    input  logic                  spi_finished,
    input  logic [WID-1:0]        spi_from_slave,
    output logic                  spi_arm,
    output logic [WID-1:0]        spi_to_slave,
    input  logic                  rd_en,
    output logic [WID-1:0]        rd_data,
    output logic                  rd_valid,
    output logic [FIFO_AW:0]      fifo_level,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic                  busy
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [PERIOD_WID-1:0] TMR_ONE = PERIOD_WID'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_DISARM,
        S_WAIT
    } state_t;

    state_t state, state_d;

    logic                  arm_start;
    logic                  push_req;
    logic                  timer_due;
    logic [PERIOD_WID-1:0] timer;

    logic [WID-1:0]     mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               full;
    logic               push;
    logic               pop;

    // The WAIT->ARM decision edge is itself the last counted cycle, so
    // leaving at timer==1 puts successive arm rises exactly period apart.
    assign timer_due = (timer <= TMR_ONE);

    always_comb begin
        state_d   = state;
        arm_start = 1'b0;
        push_req  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable && spi_ready_to_arm) begin
                    state_d   = S_ARM;
                    arm_start = 1'b1;
                end
            end
            S_ARM: begin
                if (spi_finished) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                push_req = 1'b1;
                state_d  = S_DISARM;
            end
            S_DISARM: begin
                if (spi_ready_to_arm) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (timer_due && spi_ready_to_arm) begin
                    state_d   = S_ARM;
                    arm_start = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            spi_arm      <= 1'b0;
            spi_to_slave <= '0;
            timer        <= '0;
        end else begin
            state <= state_d;
            if (arm_start) begin
                spi_to_slave <= cmd;
                spi_arm      <= 1'b1;
                timer        <= period;
            end else begin
                if (timer != '0) timer <= timer - TMR_ONE;
                if (push_req) spi_arm <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

    // FIFO: a pop in the same cycle frees the slot a full-FIFO push needs.
    assign full     = (level == LVL_FULL);
    assign rd_valid = (level != '0);
    assign pop      = rd_en && rd_valid;
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push) begin
                level <= level - LVL_ONE;
            end
            if (push_req && !push) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= spi_from_slave;
    end

    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;

endmodule

// File: tb/tb_spi_sample_sequencer.sv
// tb_spi_sample_sequencer: directed bench for spi_sample_sequencer with a
// behavioural spi_master_ss handshake model.
module tb_spi_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] cmd = '0;
    logic [15:0] period = '0;
    logic        spi_ready_to_arm;
    logic        spi_finished;
    logic [23:0] spi_from_slave;
    logic        spi_arm;
    logic [23:0] spi_to_slave;
    logic        rd_en = 1'b0;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        clr_overflow = 1'b0;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int lat = 10;
    int idx;
    int cnt;

    spi_sample_sequencer #(
        .WID(24),
        .PERIOD_WID(16),
        .FIFO_AW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .cmd(cmd),
        .period(period),
        .spi_ready_to_arm(spi_ready_to_arm),
        .spi_finished(spi_finished),
        .spi_from_slave(spi_from_slave),
        .spi_arm(spi_arm),
        .spi_to_slave(spi_to_slave),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .clr_overflow(clr_overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] word(input int i);
        return 24'h3C0000 + 24'(i * 37);
    endfunction

    // SPI master model: finished rises lat cycles after arm is seen,
    // ready_to_arm returns the cycle after arm drops.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_ready_to_arm <= 1'b1;
            spi_finished     <= 1'b0;
            spi_from_slave   <= '0;
            cnt              <= 0;
            idx              <= 0;
        end else if (!spi_arm) begin
            spi_finished     <= 1'b0;
            spi_ready_to_arm <= 1'b1;
            cnt              <= 0;
        end else if (!spi_finished) begin
            spi_ready_to_arm <= 1'b0;
            if (cnt + 1 == lat) begin
                spi_finished   <= 1'b1;
                spi_from_slave <= word(idx);
                idx            <= idx + 1;
            end
            cnt <= cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return spi_arm;
            1: return spi_finished;
            default: return busy;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input logic want,
                            input int max, output int n);
        n = 0;
        while (sig(sel) !== want && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(sig(sel)), 32'(want));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        rd_en = 1'b0;
        clr_overflow = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input int i);
        chk(tag, 32'(rd_data), 32'(word(i)));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n1, n2, arms;

        // reset state
        tick();
        chk("rst_arm", 32'(spi_arm), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_data", 32'(rd_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_tx", 32'(spi_to_slave), 0);
        do_reset();

        // periodic sampling, period 200, slave latency 50
        lat = 50;
        period = 16'd200;
        cmd = 24'hA5A5A5;
        enable = 1'b1;
        wait_for("a_arm0", 0, 1'b1, 20, n);
        chk("a_tx0", 32'(spi_to_slave), 32'h00A5A5A5);
        cmd = 24'h111111;
        wait_for("a_fall0", 0, 1'b0, 300, n1);
        chk("a_latch", 32'(spi_to_slave), 32'h00A5A5A5);
        chk("a_lvl1", 32'(fifo_level), 1);
        chk("a_head", 32'(rd_data), 32'(word(0)));
        wait_for("a_arm1", 0, 1'b1, 300, n2);
        chk("a_space1", 32'(n1 + n2), 200);
        chk("a_tx1", 32'(spi_to_slave), 32'h00111111);
        wait_for("a_fall1", 0, 1'b0, 300, n1);
        wait_for("a_arm2", 0, 1'b1, 300, n2);
        chk("a_space2", 32'(n1 + n2), 200);
        // drop enable while armed: transfer completes, then idle
        enable = 1'b0;
        wait_for("a_fall2", 0, 1'b0, 300, n);
        wait_for("a_idle", 2, 1'b0, 20, n);
        chk("a_lvl3", 32'(fifo_level), 3);
        arms = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (spi_arm) arms++;
        end
        chk("a_noarm", 32'(arms), 0);
        for (int i = 0; i < 3; i++) pop_chk("a_pop", i);
        chk("a_empty", 32'(rd_valid), 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("a_pop_empty", 32'(fifo_level), 0);

        // back-to-back, overflow after 6 transfers on a 4-deep FIFO
        do_reset();
        lat = 10;
        period = 16'd0;
        enable = 1'b1;
        n1 = 0;
        for (int t = 0; t < 6; t++) begin
            wait_for("b_arm", 0, 1'b1, 40, n2);
            if (t > 0) chk("b_space", 32'(n1 + n2), 15);
            wait_for("b_fall", 0, 1'b0, 40, n1);
            chk("b_lvl", 32'(fifo_level), 32'((t < 3) ? t + 1 : 4));
            if (t == 3) chk("b_noovf", 32'(overflow), 0);
        end
        enable = 1'b0;
        wait_for("b_idle", 2, 1'b0, 20, n);
        chk("b_full", 32'(fifo_level), 4);
        chk("b_ovf", 32'(overflow), 1);
        for (int i = 0; i < 4; i++) pop_chk("b_pop", i);
        chk("b_empty", 32'(rd_valid), 0);
        chk("b_ovf_hold", 32'(overflow), 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("b_ovf_clr", 32'(overflow), 0);

        // full FIFO with a pop in the capture cycle
        do_reset();
        enable = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_for("c_arm", 0, 1'b1, 40, n);
            wait_for("c_fall", 0, 1'b0, 40, n);
        end
        chk("c_full", 32'(fifo_level), 4);
        wait_for("c_arm4", 0, 1'b1, 40, n);
        wait_for("c_fin", 1, 1'b1, 40, n);
        tick();
        rd_en = 1'b1;
        enable = 1'b0;
        tick();
        rd_en = 1'b0;
        chk("c_lvl", 32'(fifo_level), 4);
        chk("c_ovf", 32'(overflow), 0);
        chk("c_disarm", 32'(spi_arm), 0);
        wait_for("c_idle", 2, 1'b0, 20, n);
        for (int i = 1; i < 5; i++) pop_chk("c_pop", i);
        chk("c_empty", 32'(rd_valid), 0);

        // asynchronous reset while armed
        do_reset();
        enable = 1'b1;
        wait_for("d_arm0", 0, 1'b1, 40, n);
        wait_for("d_fall0", 0, 1'b0, 40, n);
        wait_for("d_arm1", 0, 1'b1, 40, n);
        chk("d_lvl", 32'(fifo_level), 1);
        rst = 1'b1;
        #1;
        chk("d_arm", 32'(spi_arm), 0);
        chk("d_busy", 32'(busy), 0);
        chk("d_level", 32'(fifo_level), 0);
        chk("d_valid", 32'(rd_valid), 0);
        chk("d_tx", 32'(spi_to_slave), 0);
        enable = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
